// File: rtl/stopwatch_timer_if.sv
// stopwatch_timer_if
// Groups the control, preset, count and lap signals of the stopwatch/timer.
//   master : drives en/pause/clear/dir/load/load_*/lap, observes the outputs
//   slave  : the stopwatch_timer block itself
// W must match the W of the stopwatch_timer instance it connects to.
interface stopwatch_timer_if #(
  parameter int W = 6
);
  logic         en;
  logic         pause;
  logic         clear;
  logic         dir;
  logic         load;
  logic [W-1:0] load_h;
  logic [W-1:0] load_m;
  logic [W-1:0] load_s;
  logic         lap;
  logic [W-1:0] outh;
  logic [W-1:0] outm;
  logic [W-1:0] outs;
  logic [W-1:0] laph;
  logic [W-1:0] lapm;
  logic [W-1:0] laps;
  logic         lap_valid;
  logic         wrap;
  logic         expired;

  modport master (
    output en, pause, clear, dir, load, load_h, load_m, load_s, lap,
    input  outh, outm, outs, laph, lapm, laps, lap_valid, wrap, expired
  );

  modport slave (
    input  en, pause, clear, dir, load, load_h, load_m, load_s, lap,
    output outh, outm, outs, laph, lapm, laps, lap_valid, wrap, expired
  );
endinterface

// File: rtl/stopwatch_timer.sv
// stopwatch_timer
// Hours/minutes/seconds stopwatch and count-down timer on the 1 Hz time base.
// Ports:
//   clk_1hz : time-base clock, one count step per rising edge
//   rst     : asynchronous active-low reset
//   bus     : stopwatch_timer_if.slave -- controls (en, pause, clear, dir,
//             load, load_h/m/s, lap) in; count (outh/m/s), lap (laph/m/s,
//             lap_valid) and pulses (wrap, expired) out. All outputs are
//             registered.
module stopwatch_timer #(
  parameter int W       = 6,
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60,
  parameter int HR_MOD  = 24
) (
  input  logic               clk_1hz,
  input  logic               rst,
  stopwatch_timer_if.slave   bus
);

  localparam int           WP1     = W + 1;
  // Moduli held one bit wider so a modulus of 2^W is representable.
  localparam logic [W:0]   SEC_M   = WP1'(SEC_MOD);
  localparam logic [W:0]   MIN_M   = WP1'(MIN_MOD);
  localparam logic [W:0]   HR_M    = WP1'(HR_MOD);
  localparam logic [W-1:0] SEC_MAX = W'(SEC_MOD - 1);
  localparam logic [W-1:0] MIN_MAX = W'(MIN_MOD - 1);
  localparam logic [W-1:0] HR_MAX  = W'(HR_MOD - 1);
  localparam logic [W-1:0] ZERO    = {W{1'b0}};
  localparam logic [W-1:0] ONE     = W'(1);

  // Clamp a preset to modulus-1 when it is at or above the modulus.
  function automatic logic [W-1:0] sat(input logic [W-1:0] v,
                                       input logic [W:0]   modv,
                                       input logic [W-1:0] maxv);
    if ({1'b0, v} >= modv) begin
      return maxv;
    end else begin
      return v;
    end
  endfunction

  logic [W-1:0] h_q, m_q, s_q, h_d, m_d, s_d;
  logic [W-1:0] lh_q, lm_q, ls_q, lh_d, lm_d, ls_d;
  logic         lapv_q, lapv_d;
  logic         wrap_q, wrap_d;
  logic         exp_q, exp_d;
  logic         at_zero_s;

  assign at_zero_s = (h_q == ZERO) && (m_q == ZERO) && (s_q == ZERO);

  // Next-state: clear > load > count, with lap capture beside load/count.
  always_comb begin
    h_d    = h_q;
    m_d    = m_q;
    s_d    = s_q;
    lh_d   = lh_q;
    lm_d   = lm_q;
    ls_d   = ls_q;
    lapv_d = lapv_q;
    wrap_d = 1'b0;
    exp_d  = 1'b0;
    if (!bus.en) begin
      h_d = h_q;
    end else if (bus.clear) begin
      h_d    = ZERO;
      m_d    = ZERO;
      s_d    = ZERO;
      lh_d   = ZERO;
      lm_d   = ZERO;
      ls_d   = ZERO;
      lapv_d = 1'b0;
    end else begin
      // Lap samples the pre-edge count, so a same-edge load is not seen.
      if (bus.lap) begin
        lh_d   = h_q;
        lm_d   = m_q;
        ls_d   = s_q;
        lapv_d = 1'b1;
      end else begin
        lapv_d = lapv_q;
      end

      if (bus.load) begin
        h_d = sat(bus.load_h, HR_M, HR_MAX);
        m_d = sat(bus.load_m, MIN_M, MIN_MAX);
        s_d = sat(bus.load_s, SEC_M, SEC_MAX);
      end else if (bus.pause) begin
        h_d = h_q;
      end else if (!bus.dir) begin
        if (s_q == SEC_MAX) begin
          s_d = ZERO;
          if (m_q == MIN_MAX) begin
            m_d = ZERO;
            if (h_q == HR_MAX) begin
              h_d    = ZERO;
              wrap_d = 1'b1;
            end else begin
              h_d = h_q + ONE;
            end
          end else begin
            m_d = m_q + ONE;
          end
        end else begin
          s_d = s_q + ONE;
        end
      end else if (at_zero_s) begin
        // Timer parks at 0:0:0 with no further pulse.
        h_d = h_q;
      end else begin
        // Not all-zero here, so a borrow out of minutes always finds h_q > 0.
        if (s_q != ZERO) begin
          s_d = s_q - ONE;
        end else begin
          s_d = SEC_MAX;
          if (m_q != ZERO) begin
            m_d = m_q - ONE;
          end else begin
            m_d = MIN_MAX;
            h_d = h_q - ONE;
          end
        end
        exp_d = (h_q == ZERO) && (m_q == ZERO) && (s_q == ONE);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      h_q    <= ZERO;
      m_q    <= ZERO;
      s_q    <= ZERO;
      lh_q   <= ZERO;
      lm_q   <= ZERO;
      ls_q   <= ZERO;
      lapv_q <= 1'b0;
      wrap_q <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      h_q    <= h_d;
      m_q    <= m_d;
      s_q    <= s_d;
      lh_q   <= lh_d;
      lm_q   <= lm_d;
      ls_q   <= ls_d;
      lapv_q <= lapv_d;
      wrap_q <= wrap_d;
      exp_q  <= exp_d;
    end
  end

  assign bus.outh      = h_q;
  assign bus.outm      = m_q;
  assign bus.outs      = s_q;
  assign bus.laph      = lh_q;
  assign bus.lapm      = lm_q;
  assign bus.laps      = ls_q;
  assign bus.lap_valid = lapv_q;
  assign bus.wrap      = wrap_q;
  assign bus.expired   = exp_q;

endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
- Parametrised successor to the minutes/seconds stopwatch, run on the 1 Hz time base.
- Adds an hours field, configurable field moduli, count-down timer mode with expiry, preset load, lap capture, and a wrap indication.
- Sits beside the clock and alarm blocks. `en` is driven by the top-level mode decode, so the block acts only while its mode is selected.

Parameters:
- W, 6, bit width of each time field (hours, minutes, seconds)
- SEC_MOD, 60, seconds modulus; legal values 2..2^W
- MIN_MOD, 60, minutes modulus; legal values 2..2^W
- HR_MOD, 24, hours modulus; legal values 2..2^W

Ports:
- clk_1hz  in  1  time-base clock; one count step per rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  block enable (mode selected); when 0, all state is frozen except reset
- pause  in  1  level input; 1 holds the count
- clear  in  1  synchronous clear of the count and lap registers
- dir  in  1  0 = count up (stopwatch), 1 = count down (timer)
- load  in  1  synchronous preset from load_h, load_m, load_s
- load_h, load_m, load_s  in  W each  preset values
- lap  in  1  capture the current count into the lap registers
- outh, outm, outs  out  W each  current hours, minutes, seconds
- laph, lapm, laps  out  W each  captured lap value
- lap_valid  out  1  sticky; set by a lap capture
- wrap  out  1  one-cycle pulse on up-count rollover
- expired  out  1  one-cycle pulse when the down-count reaches zero

Behaviour:
- Reset (rst=0, asynchronous): every output and register goes to 0.
- en=0: all registers hold. clear, load, lap and pause are ignored. wrap and expired drive 0 on the next edge.
- en=1, per rising edge, priority order:
  - clear, then load, then count. lap is evaluated in parallel with load and count, but not with clear.
- clear=1: count, lap registers and lap_valid go to 0. wrap and expired go to 0. clear wins over a simultaneous lap.
- load=1 (clear=0): each field is loaded from its preset.
  - A preset greater than or equal to its modulus saturates to modulus-1.
  - No counting on that edge. wrap and expired are 0.
- Counting requires pause=0, clear=0 and load=0.
- Up-count (dir=0):
  - outs increments by 1.
  - At SEC_MOD-1, outs goes to 0 and carries into outm.
  - At MIN_MOD-1 with a carry, outm goes to 0 and carries into outh.
  - At HR_MOD-1 with a carry, outh goes to 0 and wrap=1 for exactly that cycle.
  - All moduli compares use the pre-edge value. The result never equals or exceeds a modulus.
- Down-count (dir=1):
  - outs decrements by 1.
  - At 0 with a nonzero higher field, outs goes to SEC_MOD-1 and borrows from outm; outm likewise borrows from outh.
  - The edge on which the count becomes 0:0:0 asserts expired for that cycle only.
  - At 0:0:0 the count holds. No re-pulse, no underflow. It stays there until load, clear, or dir=0.
- Switching dir mid-run takes effect on the next counting edge. No extra step occurs.
- lap=1 (en=1, clear=0):
  - laph/lapm/laps capture the pre-edge outh/outm/outs.
  - lap_valid goes to 1 and stays set until clear or reset.
  - lap works while paused. A lap on the same edge as a load captures the pre-load value.
- Outputs are registered, so count latency is one clk_1hz edge.
- Pulses (wrap, expired) are registered and are 0 on any edge that does not cause their event.

Test Plan:
- Reset, then en=1, pause=0, dir=0 for 61 edges -> outm=1, outs=1, wrap=0.
- load 23:59:58, dir=0, 2 edges -> second edge gives 00:00:00 with wrap=1 for one cycle only; the next edge gives 00:00:01 with wrap=0.
- load 0:1:2 with dir=1, run 62 edges -> 0:0:0 with expired=1 on edge 62; 5 further edges hold 0:0:0 with expired=0.
- Count to 0:0:10, assert lap and pause together for 3 edges -> laps=10, lap_valid=1, outs stays 10. Then assert clear and lap together -> everything 0, lap_valid=0.
- load_s=63, load_m=60 (defaults) -> outs=59, outm=59. Drop en mid-count -> values frozen. Pulse rst low between edges -> outputs 0 immediately, with no clock edge.
